lane_serial_mux: RTL

LANE_SERIAL_MUX -- requirements
Module: lane_serial_mux

---
 rtl/lane_serial_mux_pkg.sv | 13 +
 rtl/lane_serial_mux_mux_n_w.sv | 21 ++
 rtl/lane_serial_mux.sv | 107 ++++++++++
 3 files changed

// File: rtl/lane_serial_mux_pkg.sv
// Shared types and default sizing for the lane serializer.
// Holds the FSM state type and default lane width/count constants.
package lane_serial_mux_pkg;

  localparam int DEF_W = 8;
  localparam int DEF_N = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

endpackage

// File: rtl/lane_serial_mux_mux_n_w.sv
// Combinational N:1 lane selector over a flat N*W bus.
// Returns zero for an index outside 0..N-1.
module mux_n_w #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic [N*W-1:0]         data_i,
  input  logic [$clog2(N)-1:0]   idx_i,
  output logic [W-1:0]           lane_o
);

  localparam int IW = $clog2(N);

  always_comb begin
    lane_o = '0;
    for (int k = 0; k < N; k++) begin
      if (idx_i == IW'(k)) lane_o = data_i[k*W +: W];
    end
  end

endmodule

// File: rtl/lane_serial_mux.sv
// Parallel-to-serial lane streamer: accepts an N-lane word and emits
// the first 'count' lanes one per handshake, forward or reversed.
module lane_serial_mux
  import lane_serial_mux_pkg::*;
#(
  parameter int W = DEF_W,
  parameter int N = DEF_N
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N*W-1:0]          in_data,
  input  logic [$clog2(N):0]      in_count,
  input  logic                    in_rev,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [W-1:0]            out_data,
  output logic [$clog2(N)-1:0]    out_idx,
  output logic                    out_last
);

  localparam int CW = $clog2(N) + 1;
  localparam int IW = CW - 1;

  state_e          state_q, state_d;
  logic [N*W-1:0]  word_q, word_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            rev_q, rev_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            last_q, last_d;
  logic [W-1:0]    data_q;
  logic [W-1:0]    lane_sel;
  logic [CW-1:0]   eff_cnt;
  logic [IW-1:0]   idx_nxt;
  logic            accept;
  logic            out_hs;

  assign out_valid = (state_q == STREAM);
  assign out_hs    = out_valid & out_ready;
  // A new word may only enter on the handshake of the final lane.
  assign in_ready  = (state_q == IDLE) | (out_hs & last_q);
  assign accept    = in_valid & in_ready;

  assign eff_cnt = ((in_count == '0) || (in_count > CW'(N))) ? CW'(N) : in_count;
  assign idx_nxt = rev_q ? (idx_q - IW'(1)) : (idx_q + IW'(1));

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    rev_d   = rev_q;
    idx_d   = idx_q;
    last_d  = last_q;
    if (accept) begin
      state_d = STREAM;
      word_d  = in_data;
      cnt_d   = eff_cnt;
      rev_d   = in_rev;
      idx_d   = in_rev ? IW'(eff_cnt - CW'(1)) : '0;
      last_d  = (eff_cnt == CW'(1));
    end else if (out_hs) begin
      if (last_q) begin
        state_d = IDLE;
        last_d  = 1'b0;
      end else begin
        idx_d  = idx_nxt;
        last_d = rev_q ? (idx_nxt == '0) : ({1'b0, idx_nxt} == (cnt_q - CW'(1)));
      end
    end
  end

  // The mux looks at the next-state word/index so out_data is registered.
  mux_n_w #(
    .N (N),
    .W (W)
  ) u_mux (
    .data_i (word_d),
    .idx_i  (idx_d),
    .lane_o (lane_sel)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      cnt_q   <= '0;
      rev_q   <= 1'b0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      rev_q   <= rev_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      data_q  <= lane_sel;
    end
  end

  assign out_data = data_q;
  assign out_idx  = idx_q;
  assign out_last = last_q;

endmodule
